// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALU function
// codes, ALU B-operand selects and the decoded instruction class.
package multicycle_ctrl_fsm_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned OPC_BASE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [OPC_BASE_W-1:0] OPC_ADD   = 4'h0;
    localparam logic [OPC_BASE_W-1:0] OPC_SUB   = 4'h1;
    localparam logic [OPC_BASE_W-1:0] OPC_AND   = 4'h2;
    localparam logic [OPC_BASE_W-1:0] OPC_OR    = 4'h3;
    localparam logic [OPC_BASE_W-1:0] OPC_ADDI  = 4'h4;
    localparam logic [OPC_BASE_W-1:0] OPC_LOAD  = 4'h5;
    localparam logic [OPC_BASE_W-1:0] OPC_STORE = 4'h6;
    localparam logic [OPC_BASE_W-1:0] OPC_BEQ   = 4'h7;
    localparam logic [OPC_BASE_W-1:0] OPC_JMP   = 4'h8;
    localparam logic [OPC_BASE_W-1:0] OPC_HALT  = 4'hF;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        ALUB_REG  = 2'd0,
        ALUB_ONE  = 2'd1,
        ALUB_IMM  = 2'd2,
        ALUB_BOFF = 2'd3
    } alub_sel_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ADDI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_JMP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/status bundle between the control FSM (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned IR_W    = 8,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned ALUB_W  = 3
);
    logic [IR_W-1:0]    IR;
    logic               zero;
    logic               mem_ready;

    logic               RFWrite;
    logic               MemWrite;
    logic               MemRead;
    logic               PCWrite;
    logic               IRload;
    logic               MDRload;
    logic               ABLD;
    logic [ALUOP_W-1:0] ALUop;
    logic               ALUA;
    logic [ALUB_W-1:0]  ALU_B;
    logic               Addrsel;
    logic               RASel;
    logic               RegIn;
    logic [STATE_W-1:0] state_o;
    logic               halted;
    logic               illegal_op;
    logic               retire;

    modport master (
        input  IR, zero, mem_ready,
        output RFWrite, MemWrite, MemRead, PCWrite, IRload, MDRload, ABLD,
               ALUop, ALUA, ALU_B, Addrsel, RASel, RegIn,
               state_o, halted, illegal_op, retire
    );

    modport slave (
        output IR, zero, mem_ready,
        input  RFWrite, MemWrite, MemRead, PCWrite, IRload, MDRload, ABLD,
               ALUop, ALUA, ALU_B, Addrsel, RASel, RegIn,
               state_o, halted, illegal_op, retire
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_opdecode.sv
// Opcode decoder: maps the opcode field to an instruction class and ALU function.
module multicycle_ctrl_fsm_opdecode
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output op_class_e        op_class_c,
    output alu_op_e          alu_op_c
);

    // Address-forming classes use ADD; BEQ compares through SUB.
    always_comb begin
        op_class_c = CLS_ILLEGAL;
        alu_op_c   = ALU_ADD;
        case (opcode)
            OPC_W'(OPC_ADD):   begin op_class_c = CLS_RTYPE; alu_op_c = ALU_ADD; end
            OPC_W'(OPC_SUB):   begin op_class_c = CLS_RTYPE; alu_op_c = ALU_SUB; end
            OPC_W'(OPC_AND):   begin op_class_c = CLS_RTYPE; alu_op_c = ALU_AND; end
            OPC_W'(OPC_OR):    begin op_class_c = CLS_RTYPE; alu_op_c = ALU_OR;  end
            OPC_W'(OPC_ADDI):  op_class_c = CLS_ADDI;
            OPC_W'(OPC_LOAD):  op_class_c = CLS_LOAD;
            OPC_W'(OPC_STORE): op_class_c = CLS_STORE;
            OPC_W'(OPC_BEQ):   begin op_class_c = CLS_BEQ; alu_op_c = ALU_SUB; end
            OPC_W'(OPC_JMP):   op_class_c = CLS_JMP;
            OPC_W'(OPC_HALT):  op_class_c = CLS_HALT;
            default:           op_class_c = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: walks FETCH/DECODE/EXEC/MEM/WB/BRANCH/HALT from the IR opcode
// and drives datapath enables, mux selects and retire / illegal-op / halted status.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned IR_W        = 8,
    parameter int unsigned OPC_W       = 4,
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned ALUB_W      = 3,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_ctrl_fsm_if.master bus
);

    state_e            state;
    state_e            state_nxt;
    op_class_e         op_class;
    alu_op_e           dec_alu_op;
    logic              mem_ok;
    logic              uses_rs2;
    logic [ALUB_W-1:0] exec_alub;

    multicycle_ctrl_fsm_opdecode #(.OPC_W(OPC_W)) u_opdecode (
        .opcode     (bus.IR[IR_W-1 -: OPC_W]),
        .op_class_c (op_class),
        .alu_op_c   (dec_alu_op)
    );

    assign mem_ok    = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
    assign uses_rs2  = (op_class == CLS_RTYPE) || (op_class == CLS_BEQ);
    assign exec_alub = uses_rs2 ? ALUB_W'(ALUB_REG) : ALUB_W'(ALUB_IMM);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    assign bus.state_o = reset ? STATE_W'(ST_FETCH) : STATE_W'(state);

    // Next-state and control outputs; everything is forced low while reset is high
    always_comb begin
        state_nxt      = state;
        bus.RFWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.IRload     = 1'b0;
        bus.MDRload    = 1'b0;
        bus.ABLD       = 1'b0;
        bus.ALUop      = ALUOP_W'(ALU_ADD);
        bus.ALUA       = 1'b0;
        bus.ALU_B      = ALUB_W'(ALUB_REG);
        bus.Addrsel    = 1'b0;
        bus.RASel      = 1'b0;
        bus.RegIn      = 1'b0;
        bus.halted     = 1'b0;
        bus.illegal_op = 1'b0;
        bus.retire     = 1'b0;

        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    bus.MemRead = 1'b1;
                    if (mem_ok) begin
                        bus.IRload  = 1'b1;
                        bus.PCWrite = 1'b1;
                        bus.ALU_B   = ALUB_W'(ALUB_ONE);
                        state_nxt   = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    bus.ABLD = 1'b1;
                    case (op_class)
                        CLS_JMP:  state_nxt = ST_BRANCH;
                        CLS_HALT: state_nxt = ST_HALT;
                        CLS_ILLEGAL: begin
                            bus.illegal_op = 1'b1;
                            state_nxt      = ST_FETCH;
                        end
                        default:  state_nxt = ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    bus.ALUA  = 1'b1;
                    bus.ALU_B = exec_alub;
                    bus.ALUop = ALUOP_W'(dec_alu_op);
                    case (op_class)
                        CLS_RTYPE, CLS_ADDI: state_nxt = ST_WB;
                        CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
                        CLS_BEQ: begin
                            if (bus.zero) begin
                                state_nxt = ST_BRANCH;
                            end else begin
                                bus.retire = 1'b1;
                                state_nxt  = ST_FETCH;
                            end
                        end
                        default: state_nxt = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    // Effective address stays on the bus for the whole access
                    bus.ALUA    = 1'b1;
                    bus.ALU_B   = ALUB_W'(ALUB_IMM);
                    bus.Addrsel = 1'b1;
                    case (op_class)
                        CLS_LOAD: begin
                            bus.MemRead = 1'b1;
                            if (mem_ok) begin
                                bus.MDRload = 1'b1;
                                state_nxt   = ST_WB;
                            end
                        end
                        CLS_STORE: begin
                            bus.MemWrite = 1'b1;
                            if (mem_ok) begin
                                bus.retire = 1'b1;
                                state_nxt  = ST_FETCH;
                            end
                        end
                        default: state_nxt = ST_FETCH;
                    endcase
                end
                ST_WB: begin
                    bus.RFWrite = 1'b1;
                    bus.RegIn   = (op_class == CLS_LOAD);
                    bus.ALUA    = 1'b1;
                    bus.ALU_B   = exec_alub;
                    bus.ALUop   = ALUOP_W'(dec_alu_op);
                    bus.retire  = 1'b1;
                    state_nxt   = ST_FETCH;
                end
                ST_BRANCH: begin
                    // PC already holds PC+1, so the offset is relative to the next instruction
                    bus.ALU_B   = ALUB_W'(ALUB_BOFF);
                    bus.PCWrite = 1'b1;
                    bus.retire  = 1'b1;
                    state_nxt   = ST_FETCH;
                end
                ST_HALT: begin
                    bus.halted = 1'b1;
                end
                default: state_nxt = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed reset/halt/trace checks plus a random
// instruction stream scored per instruction against a latency/enable-count model.
module tb_multicycle_ctrl_fsm;
    import multicycle_ctrl_fsm_pkg::*;

    localparam int unsigned IR_W    = 8;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned ALUB_W  = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multicycle_ctrl_fsm_if #(.IR_W(IR_W), .ALUOP_W(ALUOP_W), .ALUB_W(ALUB_W)) bus ();

    multicycle_ctrl_fsm #(
        .IR_W(IR_W), .OPC_W(OPC_W), .ALUOP_W(ALUOP_W), .ALUB_W(ALUB_W), .MEM_WAIT_EN(1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-instruction footprint
    typedef struct {
        bit illegal;
        int cycles;
        int rf;
        int regin;
        int memrd;
        int memwr;
        int mdr;
        int pcw;
        int brpcw;
        int abld;
        int end_ctrl;
    } exp_t;

    exp_t sb_q[$];

    function automatic int pack(input int alua, input int alub, input int aluop, input int addr);
        return alua * 128 + alub * 16 + aluop * 2 + addr;
    endfunction

    function automatic exp_t model(input int opc, input bit z, input int fw, input int mw);
        exp_t e;
        e = '{default: 0};
        e.abld  = 1;
        e.pcw   = 1;
        e.memrd = fw + 1;
        case (opc)
            0, 1, 2, 3: begin e.cycles = 4; e.rf = 1; e.end_ctrl = pack(1, 0, opc, 0); end
            4: begin e.cycles = 4; e.rf = 1; e.end_ctrl = pack(1, 2, 0, 0); end
            5: begin
                e.cycles = 5 + mw; e.rf = 1; e.regin = 1; e.mdr = 1;
                e.memrd += mw + 1; e.end_ctrl = pack(1, 2, 0, 0);
            end
            6: begin e.cycles = 4 + mw; e.memwr = mw + 1; e.end_ctrl = pack(1, 2, 0, 1); end
            7: begin
                if (z) begin e.cycles = 4; e.pcw = 2; e.brpcw = 1; e.end_ctrl = pack(0, 3, 0, 0); end
                else   begin e.cycles = 3; e.end_ctrl = pack(1, 0, 1, 0); end
            end
            8: begin e.cycles = 3; e.pcw = 2; e.brpcw = 1; e.end_ctrl = pack(0, 3, 0, 0); end
            default: begin e.illegal = 1'b1; e.cycles = 2; e.end_ctrl = 0; end
        endcase
        e.cycles += fw;
        return e;
    endfunction

    function automatic int any_out();
        return int'({bus.RFWrite, bus.MemWrite, bus.MemRead, bus.PCWrite, bus.IRload,
                     bus.MDRload, bus.ABLD, bus.ALUop, bus.ALUA, bus.ALU_B, bus.Addrsel,
                     bus.RASel, bus.RegIn, bus.halted, bus.illegal_op, bus.retire, bus.state_o});
    endfunction

    // Monitor: accumulates activity per instruction, scores it on retire / illegal_op
    bit   mon_en = 1'b0;
    int   c_cyc, c_rf, c_regin, c_memrd, c_memwr, c_mdr, c_pcw, c_brpcw, c_abld, c_rasel, c_halt;
    exp_t mon_e;

    task automatic clr_counts();
        c_cyc = 0; c_rf = 0; c_regin = 0; c_memrd = 0; c_memwr = 0; c_mdr = 0;
        c_pcw = 0; c_brpcw = 0; c_abld = 0; c_rasel = 0; c_halt = 0;
    endtask

    always @(negedge clock) begin
        if (!mon_en) begin
            clr_counts();
        end else begin
            c_cyc++;
            if (bus.RFWrite) begin c_rf++; if (bus.RegIn) c_regin++; end
            if (bus.MemRead)  c_memrd++;
            if (bus.MemWrite) c_memwr++;
            if (bus.MDRload)  c_mdr++;
            if (bus.PCWrite) begin c_pcw++; if (bus.ALU_B == 3'd3) c_brpcw++; end
            if (bus.ABLD)     c_abld++;
            if (bus.RASel)    c_rasel++;
            if (bus.halted)   c_halt++;
            if (bus.IRload)
                chk("fetch_ctrl", int'({bus.ALUA, bus.ALU_B, bus.ALUop, bus.Addrsel}), pack(0, 1, 0, 0));
            if (bus.retire || bus.illegal_op) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_end", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("illegal_flag", int'(bus.illegal_op), int'(mon_e.illegal));
                    chk("retire_flag",  int'(bus.retire),     int'(!mon_e.illegal));
                    chk("cycles",   c_cyc,   mon_e.cycles);
                    chk("rfwrite",  c_rf,    mon_e.rf);
                    chk("regin",    c_regin, mon_e.regin);
                    chk("memread",  c_memrd, mon_e.memrd);
                    chk("memwrite", c_memwr, mon_e.memwr);
                    chk("mdrload",  c_mdr,   mon_e.mdr);
                    chk("pcwrite",  c_pcw,   mon_e.pcw);
                    chk("br_pcwrite", c_brpcw, mon_e.brpcw);
                    chk("abld",     c_abld,  mon_e.abld);
                    chk("rasel",    c_rasel, 0);
                    chk("halted",   c_halt,  0);
                    chk("end_ctrl", int'({bus.ALUA, bus.ALU_B, bus.ALUop, bus.Addrsel}), mon_e.end_ctrl);
                end
                clr_counts();
            end
        end
    end

    // Drives one instruction: fw fetch wait cycles, mw memory wait cycles
    task automatic run_instr(input int opc, input bit z, input int fw, input int mw);
        exp_t e;
        logic [3:0] lo;
        e  = model(opc, z, fw, mw);
        lo = 4'($urandom_range(0, 15));
        sb_q.push_back(e);
        bus.IR = {4'(opc), lo};
        for (int i = 0; i < e.cycles; i++) begin
            bus.mem_ready = !((i < fw) || (i >= fw + 3 && i < fw + 3 + mw));
            bus.zero      = (i == fw + 2) ? z : 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int add_st[4];
        int bad;
        int opc, mw;
        add_st = '{0, 1, 2, 4};

        bus.IR = 8'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outs", any_out(), 0);
        chk("reset_state", int'(bus.state_o), 0);

        // ADD trace
        reset = 1'b0; bus.IR = 8'h01;
        for (int i = 0; i < 4; i++) begin
            chk("add_state",  int'(bus.state_o), add_st[i]);
            chk("add_rfwrite", int'(bus.RFWrite), int'(i == 3));
            chk("add_retire",  int'(bus.retire),  int'(i == 3));
            @(posedge clock); #1;
        end
        chk("add_back_fetch", int'(bus.state_o), 0);

        // Reset held 3 cycles in the middle of a LOAD
        bus.IR = 8'h52;
        repeat (3) begin @(posedge clock); #1; end
        bus.mem_ready = 1'b0; #1;
        chk("load_in_mem", int'(bus.state_o), 3);
        chk("load_memread", int'(bus.MemRead), 1);
        @(posedge clock); #1;
        reset = 1'b1; bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("midload_reset_outs", any_out(), 0);
            @(posedge clock); #1;
        end
        reset = 1'b0; #1;
        chk("post_reset_state", int'(bus.state_o), 0);
        chk("post_reset_memread", int'(bus.MemRead), 1);
        chk("post_reset_mdrload", int'(bus.MDRload), 0);
        chk("post_reset_rfwrite", int'(bus.RFWrite), 0);

        // Scoreboarded instruction stream
        mon_en = 1'b1;
        run_instr(5, 1'b0, 0, 2);
        run_instr(7, 1'b1, 0, 0);
        run_instr(7, 1'b0, 0, 0);
        run_instr(10, 1'b0, 0, 0);
        run_instr(8, 1'b0, 1, 0);
        run_instr(6, 1'b0, 1, 2);
        for (int n = 0; n < 200; n++) begin
            opc = $urandom_range(0, 14);
            mw  = (opc == 5 || opc == 6) ? $urandom_range(0, 3) : 0;
            run_instr(opc, 1'($urandom_range(0, 1)), $urandom_range(0, 2), mw);
        end
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clock);
        chk("sb_drain", sb_q.size(), 0);
        mon_en = 1'b0;

        // HALT is sticky regardless of inputs
        bus.IR = 8'hF7; bus.mem_ready = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!bus.halted || bus.state_o != 3'd6 ||
                (bus.RFWrite | bus.MemWrite | bus.MemRead | bus.PCWrite | bus.IRload |
                 bus.MDRload | bus.ABLD | bus.retire | bus.illegal_op))
                bad++;
            bus.IR        = 8'($urandom_range(0, 255));
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.zero      = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        chk("halt_hold", bad, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; bus.mem_ready = 1'b1; #1;
        chk("halt_recover_state", int'(bus.state_o), 0);
        chk("halt_recover_halted", int'(bus.halted), 0);
        chk("halt_recover_irload", int'(bus.IRload), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
